ps2_scan_rx: RTL



---
 rtl/ps2_scan_rx_pkg.sv | 25 ++
 rtl/ps2_scan_rx_if.sv | 14 +
 rtl/ps2_scan_rx_sync_fifo.sv | 47 ++++
 rtl/ps2_scan_rx.sv | 100 ++++++++++
 4 files changed

// File: rtl/ps2_scan_rx_pkg.sv
// Shared constants and frame helpers for the PS/2 scancode receiver and the
// downstream decoders.
package ps2_scan_rx_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  localparam logic PS2_START = 1'b0;
  localparam logic PS2_STOP  = 1'b1;

  localparam logic [7:0] PS2_BREAK_PREFIX    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED_PREFIX = 8'hE0;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_GOOD,
    FRAME_BAD
  } frame_status_e;

  // Frame layout, LSB first: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
    return (frame[0] == PS2_START) && (frame[10] == PS2_STOP) && ((^frame[9:1]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Consumer-side bus of the PS/2 receiver: scancode head, pop handshake and status.
interface ps2_scan_rx_if;
  import ps2_scan_rx_pkg::*;

  logic                     rd_en;
  logic                     ovf_clr;
  logic [PS2_DATA_BITS-1:0] data;
  logic                     ready;
  logic                     overflow;
  logic [7:0]               err_cnt;

  modport master (output data, ready, overflow, err_cnt, input rd_en, ovf_clr);
  modport slave  (input data, ready, overflow, err_cnt, output rd_en, ovf_clr);
endinterface

// File: rtl/ps2_scan_rx_sync_fifo.sv
// Generic synchronous FIFO with one-extra-bit pointers; push is ignored when
// full and pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Storage is cleared on reset so the head output reads zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver: synchronises the raw lines, assembles 11-bit
// frames, checks framing/parity and queues good scancodes in a FIFO.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_scan_rx_if.master     bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    r_clk_sync;
  logic [2:0]    r_data_sync;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_overflow;
  logic [7:0]    r_err_cnt;

  logic                      w_fall;
  logic                      w_bit;
  logic                      w_timeout;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic [PS2_FRAME_BITS-1:0] w_frame;
  frame_status_e             w_status;

  // Stage 3 is the oldest sample; a fall is seen when stage 3 is still high
  assign w_fall    = r_clk_sync[2] && !r_clk_sync[1];
  assign w_bit     = r_data_sync[2];
  assign w_frame   = {w_bit, r_shift};
  assign w_timeout = !w_fall && (r_bit_cnt != 4'd0) && (r_tmo_cnt == TMO_MAX);
  assign w_push    = (w_status == FRAME_GOOD);

  always_comb begin
    w_status = FRAME_NONE;
    if (w_fall && (r_bit_cnt == LAST_BIT))
      w_status = ps2_frame_ok(w_frame) ? FRAME_GOOD : FRAME_BAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 10'd0;
      r_tmo_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[1:0], ps2_data};

      if (w_fall) begin
        r_shift   <= {w_bit, r_shift[9:1]};
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? 4'd0 : r_bit_cnt + 4'd1;
      end else if (w_timeout) begin
        r_bit_cnt <= 4'd0;
      end

      if (w_fall || w_timeout || (r_bit_cnt == 4'd0)) r_tmo_cnt <= '0;
      else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;

      // A new overflow beats a simultaneous clear
      if (w_push && w_full)  r_overflow <= 1'b1;
      else if (bus.ovf_clr)  r_overflow <= 1'b0;

      if (((w_status == FRAME_BAD) || w_timeout) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_frame[8:1]),
    .i_pop   (bus.rd_en),
    .o_rdata (bus.data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.ready    = !w_empty;
  assign bus.overflow = r_overflow;
  assign bus.err_cnt  = r_err_cnt;

endmodule
